// File: rtl/sram_port_arbiter_if.sv
// SRAM-like port bundle: request/address phase plus accept and response handshakes.
// The master drives the request fields and the slave drives the handshakes and read data.
interface sram_port_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like port between fetch (inst) and data requesters, with fixed data priority,
// a grant held until accept, and an issue-order FIFO that steers each response to its issuer.
module sram_port_arbiter #(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic                clk,
  input  logic                resetn,
  sram_port_arbiter_if.slave  inst,
  sram_port_arbiter_if.slave  data,
  sram_port_arbiter_if.master m,
  output logic                err_spurious
);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic ID_INST = 1'b0;
  localparam logic ID_DATA = 1'b1;
  localparam logic [PW-1:0] PTR_LAST = PW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(MAX_OUTSTANDING);

  logic [MAX_OUTSTANDING-1:0] order_q;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          lock_valid_q, lock_valid_d;
  logic          lock_id_q, lock_id_d;
  logic          err_q, err_d;

  logic full, gnt_valid, gnt_id, gnt_req, push, pop, head_id;

  // A held lock overrides priority so an offered address never changes before it is accepted.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_id    = ID_INST;
    if (lock_valid_q) begin
      gnt_valid = 1'b1;
      gnt_id    = lock_id_q;
    end else if (data.req) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_DATA;
    end else if (inst.req) begin
      gnt_valid = 1'b1;
      gnt_id    = ID_INST;
    end
  end

  assign full    = (count_q == CNT_FULL);
  assign gnt_req = gnt_valid && ((gnt_id == ID_DATA) ? data.req : inst.req);

  assign m.req   = !full && gnt_req;
  assign m.wr    = (gnt_id == ID_DATA) ? data.wr    : inst.wr;
  assign m.size  = (gnt_id == ID_DATA) ? data.size  : inst.size;
  assign m.addr  = (gnt_id == ID_DATA) ? data.addr  : inst.addr;
  assign m.wdata = (gnt_id == ID_DATA) ? data.wdata : inst.wdata;

  assign push    = m.req && m.addr_ok;
  assign pop     = m.data_ok && (count_q != '0);
  assign head_id = order_q[rd_ptr_q];

  assign inst.addr_ok = push && (gnt_id == ID_INST);
  assign data.addr_ok = push && (gnt_id == ID_DATA);
  assign inst.data_ok = pop && (head_id == ID_INST);
  assign data.data_ok = pop && (head_id == ID_DATA);
  assign inst.rdata   = m.rdata;
  assign data.rdata   = m.rdata;
  assign err_spurious = err_q;

  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    lock_valid_d = lock_valid_q;
    lock_id_d    = lock_id_q;
    err_d        = err_q;

    if (push) wr_ptr_d = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + 1'b1;

    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase

    if (m.req && !m.addr_ok) begin
      lock_valid_d = 1'b1;
      lock_id_d    = gnt_id;
    end else if (push) begin
      lock_valid_d = 1'b0;
    end

    if (m.data_ok && (count_q == '0)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      lock_valid_q <= 1'b0;
      lock_id_q    <= ID_INST;
      err_q        <= 1'b0;
    end else begin
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      lock_valid_q <= lock_valid_d;
      lock_id_q    <= lock_id_d;
      err_q        <= err_d;
    end
  end

  // Entries are only read when count says they are valid, so storage needs no reset.
  always_ff @(posedge clk) begin
    if (push) order_q[wr_ptr_q] <= gnt_id;
  end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: a queue-based model is compared every cycle,
// and literal expectations at key cycles pin the model.
module tb_sram_port_arbiter;
  localparam int MAX = 2;

  logic clk = 1'b0;
  logic resetn;

  sram_port_arbiter_if inst_if ();
  sram_port_arbiter_if data_if ();
  sram_port_arbiter_if m_if ();
  logic err_spurious;

  sram_port_arbiter #(.MAX_OUTSTANDING(MAX)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst         (inst_if),
    .data         (data_if),
    .m            (m_if),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit mdl_q[$];
  int mdl_pend;
  bit mdl_err;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    inst_if.req = 1'b0; inst_if.wr = 1'b0; inst_if.size = 2'd0; inst_if.addr = 32'd0; inst_if.wdata = 32'd0;
    data_if.req = 1'b0; data_if.wr = 1'b0; data_if.size = 2'd0; data_if.addr = 32'd0; data_if.wdata = 32'd0;
    m_if.addr_ok = 1'b0; m_if.data_ok = 1'b0; m_if.rdata = 32'd0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Model: winner is the side still waiting on its offer, otherwise data, otherwise inst.
  initial begin : compare
    int win;
    bit full, ereq, eaok, pop, head;
    logic [31:0] e_addr, e_wdata;
    logic e_wr;
    logic [1:0] e_size;
    mdl_pend = -1;
    mdl_err  = 1'b0;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        mdl_q.delete();
        mdl_pend = -1;
        mdl_err  = 1'b0;
        chk("rst_m_req", m_if.req, 0);
        chk("rst_m_addr", m_if.addr, 0);
        chk("rst_inst_addr_ok", inst_if.addr_ok, 0);
        chk("rst_data_addr_ok", data_if.addr_ok, 0);
        chk("rst_inst_data_ok", inst_if.data_ok, 0);
        chk("rst_data_data_ok", data_if.data_ok, 0);
        chk("rst_err", err_spurious, 0);
      end else begin
        full = (mdl_q.size() == MAX);
        if (mdl_pend >= 0)    win = mdl_pend;
        else if (data_if.req) win = 1;
        else if (inst_if.req) win = 0;
        else                  win = -1;
        ereq = !full && ((win == 1 && data_if.req) || (win == 0 && inst_if.req));
        if (win == 1) begin
          e_wr = data_if.wr; e_size = data_if.size; e_addr = data_if.addr; e_wdata = data_if.wdata;
        end else begin
          e_wr = inst_if.wr; e_size = inst_if.size; e_addr = inst_if.addr; e_wdata = inst_if.wdata;
        end
        eaok = ereq && m_if.addr_ok;
        pop  = m_if.data_ok && (mdl_q.size() != 0);
        head = (mdl_q.size() != 0) ? mdl_q[0] : 1'b0;

        chk("m_req", m_if.req, ereq);
        chk("m_wr", m_if.wr, e_wr);
        chk("m_size", m_if.size, e_size);
        chk("m_addr", m_if.addr, e_addr);
        chk("m_wdata", m_if.wdata, e_wdata);
        chk("inst_addr_ok", inst_if.addr_ok, eaok && win == 0);
        chk("data_addr_ok", data_if.addr_ok, eaok && win == 1);
        chk("inst_data_ok", inst_if.data_ok, pop && !head);
        chk("data_data_ok", data_if.data_ok, pop && head);
        chk("inst_rdata", inst_if.rdata, m_if.rdata);
        chk("data_rdata", data_if.rdata, m_if.rdata);
        chk("err_spurious", err_spurious, mdl_err);

        if (ereq && !m_if.addr_ok) mdl_pend = win;
        else if (eaok)             mdl_pend = -1;
        if (m_if.data_ok && mdl_q.size() == 0) mdl_err = 1'b1;
        if (pop)  void'(mdl_q.pop_front());
        if (eaok) mdl_q.push_back(win == 1);
      end
    end
  end

  initial begin : stimulus
    resetn = 1'b0;
    idle();
    step();
    step();
    @(negedge clk);
    chk("lit_reset_m_req", m_if.req, 0);
    chk("lit_reset_err", err_spurious, 0);
    step();
    resetn = 1'b1;

    // Contention: data wins, inst follows next cycle, then responses return in issue order
    step();
    data_if.req = 1'b1; data_if.wr = 1'b1; data_if.size = 2'd2;
    data_if.addr = 32'h0000_1000; data_if.wdata = 32'hDEAD_BEEF;
    inst_if.req = 1'b1; inst_if.size = 2'd2; inst_if.addr = 32'hBFC0_0000;
    m_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_cont_m_addr", m_if.addr, 32'h0000_1000);
    chk("lit_cont_data_addr_ok", data_if.addr_ok, 1);
    chk("lit_cont_inst_addr_ok", inst_if.addr_ok, 0);
    step();
    data_if.req = 1'b0;
    @(negedge clk);
    chk("lit_cont2_m_addr", m_if.addr, 32'hBFC0_0000);
    chk("lit_cont2_inst_addr_ok", inst_if.addr_ok, 1);
    step();
    inst_if.req = 1'b0; m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'h0000_AAAA;
    @(negedge clk);
    chk("lit_ret1_data_data_ok", data_if.data_ok, 1);
    chk("lit_ret1_inst_data_ok", inst_if.data_ok, 0);
    chk("lit_ret1_data_rdata", data_if.rdata, 32'h0000_AAAA);
    step();
    m_if.rdata = 32'h0000_BBBB;
    @(negedge clk);
    chk("lit_ret2_inst_data_ok", inst_if.data_ok, 1);
    chk("lit_ret2_data_data_ok", data_if.data_ok, 0);
    chk("lit_ret2_inst_rdata", inst_if.rdata, 32'h0000_BBBB);
    step();
    idle();

    // Grant hold: inst keeps the port through data's arrival until accepted
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0100;
    @(negedge clk);
    chk("lit_hold1_m_addr", m_if.addr, 32'h0000_0100);
    step();
    data_if.req = 1'b1; data_if.addr = 32'h0000_2000;
    @(negedge clk);
    chk("lit_hold2_m_addr", m_if.addr, 32'h0000_0100);
    chk("lit_hold2_data_addr_ok", data_if.addr_ok, 0);
    step();
    m_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_hold3_m_addr", m_if.addr, 32'h0000_0100);
    chk("lit_hold3_inst_addr_ok", inst_if.addr_ok, 1);
    step();
    inst_if.req = 1'b0;
    @(negedge clk);
    chk("lit_hold4_m_addr", m_if.addr, 32'h0000_2000);
    chk("lit_hold4_data_addr_ok", data_if.addr_ok, 1);
    step();
    data_if.req = 1'b0; m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1; m_if.rdata = 32'h0000_1111;
    @(negedge clk);
    chk("lit_hold_ret1_inst", inst_if.data_ok, 1);
    step();
    m_if.rdata = 32'h0000_2222;
    @(negedge clk);
    chk("lit_hold_ret2_data", data_if.data_ok, 1);
    step();
    idle();

    // Full: two accepts stall the third; push+pop keeps the count
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0010; m_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_full_acc1", inst_if.addr_ok, 1);
    step();
    inst_if.addr = 32'h0000_0014;
    @(negedge clk);
    chk("lit_full_acc2", inst_if.addr_ok, 1);
    step();
    inst_if.addr = 32'h0000_0018;
    @(negedge clk);
    chk("lit_full_stall_m_req", m_if.req, 0);
    chk("lit_full_stall_addr_ok", inst_if.addr_ok, 0);
    step();
    m_if.data_ok = 1'b1; m_if.rdata = 32'h0000_3333;
    @(negedge clk);
    chk("lit_full_pop_m_req", m_if.req, 0);
    chk("lit_full_pop_data_ok", inst_if.data_ok, 1);
    step();
    @(negedge clk);
    chk("lit_full_after_pop_m_req", m_if.req, 1);
    chk("lit_full_pushpop_data_ok", inst_if.data_ok, 1);
    step();
    m_if.data_ok = 1'b0; inst_if.addr = 32'h0000_001C;
    @(negedge clk);
    chk("lit_full_count_kept_m_req", m_if.req, 1);
    step();
    inst_if.addr = 32'h0000_0020;
    @(negedge clk);
    chk("lit_full_again_m_req", m_if.req, 0);
    step();
    inst_if.req = 1'b0; m_if.addr_ok = 1'b0; m_if.data_ok = 1'b1;
    @(negedge clk);
    chk("lit_drain1", inst_if.data_ok, 1);
    step();
    @(negedge clk);
    chk("lit_drain2", inst_if.data_ok, 1);
    step();
    idle();

    // Spurious response while empty
    m_if.data_ok = 1'b1;
    @(negedge clk);
    chk("lit_spur_inst_data_ok", inst_if.data_ok, 0);
    chk("lit_spur_data_data_ok", data_if.data_ok, 0);
    step();
    m_if.data_ok = 1'b0;
    @(negedge clk);
    chk("lit_spur_err", err_spurious, 1);
    step();

    // Asynchronous reset with one transaction outstanding
    inst_if.req = 1'b1; inst_if.addr = 32'h0000_0040; m_if.addr_ok = 1'b1;
    @(negedge clk);
    chk("lit_rst_acc", inst_if.addr_ok, 1);
    step();
    idle();
    #2 resetn = 1'b0;
    @(negedge clk);
    chk("lit_async_rst_err", err_spurious, 0);
    chk("lit_async_rst_m_req", m_if.req, 0);
    chk("lit_async_rst_inst_data_ok", inst_if.data_ok, 0);
    step();
    resetn = 1'b1;
    m_if.data_ok = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_inst_data_ok", inst_if.data_ok, 0);
    chk("lit_post_rst_data_data_ok", data_if.data_ok, 0);
    step();
    m_if.data_ok = 1'b0;
    @(negedge clk);
    chk("lit_post_rst_err", err_spurious, 1);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
